// File: rtl/iob_ram_2p_rd_stream_pkg.sv
// Shared types and buffer sizing for the RAM read-stream engine.
package iob_ram_2p_rd_stream_pkg;

  localparam int BUF_DEPTH = 4;
  localparam int BUF_PTR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/iob_ram_2p_rd_buf.sv
// 4-entry return-data FIFO; push lands next edge, head is registered storage.
// No overflow guard: the caller's credit rule bounds occupancy.
module iob_ram_2p_rd_buf
  import iob_ram_2p_rd_stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [W-1:0]         push_dat_i,
  input  logic                 pop_i,
  output logic [W-1:0]         head_dat_o,
  output logic [BUF_PTR_W:0]   count_o
);

  logic [W-1:0]           mem_q [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]   wr_ptr_q;
  logic [BUF_PTR_W-1:0]   rd_ptr_q;
  logic [BUF_PTR_W:0]     count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + BUF_PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + BUF_PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (BUF_PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (BUF_PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/iob_ram_2p_rd_stream.sv
// Streams len RAM words from start_addr onto a valid/ready port; first beat 3 cycles after start.
// Reads stop once 4 words are outstanding; IOB_RAM_RD_STREAM_LAST_EN adds m_last.
module iob_ram_2p_rd_stream
  import iob_ram_2p_rd_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef IOB_RAM_RD_STREAM_LAST_EN
  ,
  output logic              m_last
`endif
);

`ifdef IOB_RAM_RD_STREAM_LAST_EN
  localparam int BUF_W = DATA_W + 1;
`else
  localparam int BUF_W = DATA_W;
`endif

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                r_en_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [LEN_W-1:0]    remain_q;
  logic [LEN_W-1:0]    beats_q;
  logic                rd_vld_q;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
  logic                r_last_q;
  logic                rd_last_q;
`endif

  logic [BUF_W-1:0]    buf_push_dat;
  logic [BUF_W-1:0]    buf_head;
  logic [BUF_PTR_W:0]  buf_cnt;
  logic                buf_vld;
  logic                pop;
  logic [BUF_PTR_W+1:0] outstanding;
  logic                credit;

  assign buf_vld = (buf_cnt != '0);
  assign pop     = buf_vld && m_ready;

  // Words already committed: buffered, returning this cycle, and being read by the RAM now.
  assign outstanding = {1'b0, buf_cnt}
                     + {{(BUF_PTR_W+1){1'b0}}, rd_vld_q}
                     + {{(BUF_PTR_W+1){1'b0}}, r_en_q};
  assign credit = outstanding < (BUF_PTR_W+2)'(BUF_DEPTH);

`ifdef IOB_RAM_RD_STREAM_LAST_EN
  assign buf_push_dat = {rd_last_q, r_data};
`else
  assign buf_push_dat = r_data;
`endif

  iob_ram_2p_rd_buf #(
    .W (BUF_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rd_vld_q),
    .push_dat_i (buf_push_dat),
    .pop_i      (pop),
    .head_dat_o (buf_head),
    .count_o    (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_en_q   <= 1'b0;
      r_addr_q <= '0;
      remain_q <= '0;
      beats_q  <= '0;
      rd_vld_q <= 1'b0;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
      r_last_q  <= 1'b0;
      rd_last_q <= 1'b0;
`endif
    end else begin
      r_en_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= r_en_q;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
      rd_last_q <= r_last_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              // First read goes out on the accepting edge.
              r_en_q   <= 1'b1;
              r_addr_q <= start_addr;
              remain_q <= len - LEN_W'(1);
              beats_q  <= len;
              busy_q   <= 1'b1;
              state_q  <= (len == LEN_W'(1)) ? ST_FLUSH : ST_RUN;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
              r_last_q <= (len == LEN_W'(1));
`endif
            end
          end
        end
        ST_RUN: begin
          if (pop) beats_q <= beats_q - LEN_W'(1);
          if (credit) begin
            r_en_q   <= 1'b1;
            r_addr_q <= r_addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) state_q <= ST_FLUSH;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
            r_last_q <= (remain_q == LEN_W'(1));
`endif
          end
        end
        ST_FLUSH: begin
          if (pop) begin
            beats_q <= beats_q - LEN_W'(1);
            if (beats_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign r_en    = r_en_q;
  assign r_addr  = r_addr_q;
  assign m_valid = buf_vld;
  assign m_data  = buf_vld ? buf_head[DATA_W-1:0] : '0;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
  assign m_last  = buf_vld && buf_head[DATA_W];
`endif

endmodule

// File: tb/tb_iob_ram_2p_rd_stream.sv
// Bench for iob_ram_2p_rd_stream: RAM model mem[a]=a, scoreboard of expected beats.
module tb_iob_ram_2p_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] len;
  logic        busy, done, r_en, m_valid, m_ready;
  logic [9:0]  r_addr;
  logic [31:0] r_data = '0;
  logic [31:0] m_data;
`ifdef IOB_RAM_RD_STREAM_LAST_EN
  logic        m_last;
`endif

  iob_ram_2p_rd_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef IOB_RAM_RD_STREAM_LAST_EN
    ,
    .m_last     (m_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en) r_data <= {22'b0, r_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [32:0] exp_q[$];
  int          ren_cyc_q[$];
  logic [9:0]  ren_addr_q[$];
  int          beat_cyc_q[$];
  int ren_cnt = 0, done_cnt = 0, beat_cnt = 0, busy_cnt = 0, done_cyc = 0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_dat = '0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n === 1'b1) begin
      if (r_en) begin
        ren_cnt++;
        ren_cyc_q.push_back(cyc);
        ren_addr_q.push_back(r_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (stall_q && m_valid) chk("stall_hold", m_data, stall_dat);
      if (m_valid && m_ready) begin
        beat_cnt++;
        beat_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[31:0]);
`ifdef IOB_RAM_RD_STREAM_LAST_EN
          chk("beat_last", {31'b0, m_last}, {31'b0, e[32]});
`endif
        end
      end
      stall_q   = m_valid && !m_ready;
      stall_dat = m_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  int start_cyc = 0;
  int b_ren, b_done, b_beat, b_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_ren  = ren_cnt;
    b_done = done_cnt;
    b_beat = beat_cnt;
    b_busy = busy_cnt;
  endtask

  task automatic start_xfer(input logic [9:0] a, input int n);
    logic [9:0] w;
    start      = 1'b1;
    start_addr = a;
    len        = 11'(n);
    start_cyc  = cyc;
    for (int i = 0; i < n; i++) begin
      w = a + 10'(i);
      exp_q.push_back({(i == n - 1), 22'b0, w});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == b_done && n < 300) begin
      tick();
      n++;
    end
    if (done_cnt == b_done) chk("done_timeout", 32'd0, 32'd1);
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   {31'b0, busy},    32'd0);
    chk({tag, "_done"},   {31'b0, done},    32'd0);
    chk({tag, "_r_en"},   {31'b0, r_en},    32'd0);
    chk({tag, "_m_valid"},{31'b0, m_valid}, 32'd0);
    chk({tag, "_r_addr"}, {22'b0, r_addr},  32'd0);
    chk({tag, "_m_data"}, m_data,           32'd0);
  endtask

  initial begin
    logic [9:0] a;
    int n;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Wrap-around across the top of the address space.
    m_ready = 1'b1;
    snap();
    start_xfer(10'h3FE, 4);
    wait_done();
    chk("wrap_ren_cnt", 32'(ren_cnt - b_ren), 32'd4);
    for (int i = 0; i < 4; i++) begin
      a = 10'h3FE + 10'(i);
      chk("wrap_r_addr",   {22'b0, ren_addr_q[b_ren + i]}, {22'b0, a});
      chk("wrap_ren_cyc",  32'(ren_cyc_q[b_ren + i] - start_cyc), 32'(1 + i));
      chk("wrap_beat_cyc", 32'(beat_cyc_q[b_beat + i] - start_cyc), 32'(3 + i));
    end
    chk("wrap_done_cyc", 32'(done_cyc - start_cyc), 32'd7);
    chk("wrap_done_cnt", 32'(done_cnt - b_done), 32'd1);

    // Backpressure: consumer stalled through cycle 12.
    m_ready = 1'b0;
    snap();
    start_xfer(10'h100, 16);
    while (cyc - start_cyc < 13) tick();
    chk("bp_ren_before_accept", 32'(ren_cnt - b_ren), 32'd4);
    chk("bp_no_beat_stalled", 32'(beat_cnt - b_beat), 32'd0);
    m_ready = 1'b1;
    wait_done();
    chk("bp_ren_total", 32'(ren_cnt - b_ren), 32'd16);
    chk("bp_beats", 32'(beat_cnt - b_beat), 32'd16);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length request.
    snap();
    start_xfer(10'h005, 0);
    wait_done();
    chk("zero_done_cyc", 32'(done_cyc - start_cyc), 32'd1);
    chk("zero_ren", 32'(ren_cnt - b_ren), 32'd0);
    chk("zero_busy", 32'(busy_cnt - b_busy), 32'd0);

    // A second start during RUN must be ignored.
    snap();
    start_xfer(10'h010, 8);
    tick();
    start = 1'b1; start_addr = 10'h200; len = 11'd5;
    tick();
    start = 1'b0;
    wait_done();
    chk("busy_ren_total", 32'(ren_cnt - b_ren), 32'd8);
    chk("busy_beats", 32'(beat_cnt - b_beat), 32'd8);
    chk("busy_last_addr", {22'b0, ren_addr_q[ren_addr_q.size() - 1]}, 32'h017);
    chk("busy_done_cnt", 32'(done_cnt - b_done), 32'd1);
    chk("busy_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset after three of eight beats.
    snap();
    start_xfer(10'h040, 8);
    n = 0;
    while (beat_cnt - b_beat < 3 && n < 40) begin
      tick();
      n++;
    end
    chk("rstmid_reached", 32'(beat_cnt - b_beat >= 3), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("rstmid");
    rst_n = 1'b1;
    exp_q.delete();
    repeat (12) tick();
    chk("rstmid_no_done", 32'(done_cnt - b_done), 32'd0);
    snap();
    start_xfer(10'h080, 3);
    wait_done();
    chk("rstmid_new_beats", 32'(beat_cnt - b_beat), 32'd3);
    chk("rstmid_new_done_cyc", 32'(done_cyc - start_cyc), 32'd6);
    chk("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef IOB_RAM_RD_STREAM_LAST_EN
    // m_last expectations are carried in the scoreboard entries.
    snap();
    start_xfer(10'h020, 3);
    wait_done();
    start_xfer(10'h030, 1);
    wait_done();
    chk("last_beats", 32'(beat_cnt - b_beat), 32'd4);
    chk("last_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_ram_2p_rd_stream.md
# iob_ram_2p_rd_stream

Read-side streaming engine for the byte-enable two-port RAM: given a start address and a word count, it drives the RAM read port (`r_en`/`r_addr`) and absorbs its one-cycle read latency. It delivers the words in address order on a valid/ready output stream with full backpressure. It sits between a 2p RAM instance and a stream consumer (DMA, UART TX, accelerator input), so software or control logic moves a RAM region with one start pulse.

## Interface
- `DATA_W`, 32, RAM word width; multiple of 8.
- `ADDR_W`, 10, RAM address width.
- `LEN_W`, `ADDR_W+1`, width of the word count; allows a full-RAM transfer.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: transfer request; sampled only in IDLE.
- `start_addr` in ADDR_W: first word address; sampled with `start`.
- `len` in LEN_W: number of words; sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `r_en` out ADDR_W-independent 1: RAM read enable, registered.
- `r_addr` out ADDR_W: RAM read address, registered.
- `r_data` in DATA_W: RAM read data, valid the cycle after `r_en`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_W: output word.
- `m_last` out 1: present only with `IOB_RAM_RD_STREAM_LAST_EN`.

## Operation
- States: IDLE, RUN (issuing reads), FLUSH (all reads issued, buffer draining), DONE (one cycle).
- IDLE:
  - `start`=1 and `len`≠0: latch address and count, go to RUN.
  - `start`=1 and `len`=0: go to DONE; no `r_en` is issued.
  - `start` is ignored in any state other than IDLE.
- RUN:
  - A read is issued when words remain and outstanding < BUF_DEPTH (4). Outstanding = buffer occupancy + reads in flight + the read being issued.
  - `r_addr` increments by 1 per issued read and wraps modulo 2^ADDR_W.
  - After the last read is issued, go to FLUSH.
- Data return: `r_data` is written into the 4-entry FIFO the cycle after `r_en`, unconditionally, so no data is ever dropped.
- Output: `m_valid` = FIFO not empty; `m_data` = FIFO head. A beat transfers when `m_valid`&&`m_ready`.
  - `m_data` must hold stable while `m_valid`&&!`m_ready`.
- FLUSH: once the final beat transfers, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in RUN and FLUSH; `busy`=0 in IDLE and DONE.
- Reset values: `busy`, `done`, `r_en`, `m_valid` = 0; `r_addr`, `m_data` = 0; FIFO empty; state IDLE.
- Reset asserted mid-transfer aborts the transfer: in-flight data is discarded and no `done` pulse is produced.

## Timing
- `start` accepted at cycle 0 (the `start` edge): `r_en` high cycle 1, data written to the FIFO at the end of cycle 2, `m_valid` high cycle 3.
- With `m_ready` held high, throughput is 1 word/cycle sustained. The last beat is in cycle 2+len; `done` follows in cycle 3+len.
- With `m_ready` low, at most 4 words are outstanding. `r_en` stays low until a beat drains.
- `r_en`/`r_addr` come directly from flops; there is no combinational path from `m_ready` to the RAM port.
- `len`=0: `done` in cycle 1.

## Configuration
- `IOB_RAM_RD_STREAM_LAST_EN` defined: adds the `m_last` port, high with the final beat of each transfer. The FIFO carries a last bit alongside the data.
- Not defined: no `m_last` port, and the FIFO is DATA_W wide. All other behaviour is identical.

## Structure
- Package `iob_ram_2p_rd_stream_pkg` holds:
  - the state encodings (IDLE, RUN, FLUSH, DONE);
  - `BUF_DEPTH`=4 and `BUF_PTR_W`=2.
- Sub-module `iob_ram_2p_rd_buf`: a 4-entry synchronous FIFO with count output. Width = DATA_W, or DATA_W+1 with LAST_EN. Push with no overflow check; overflow is prevented by the credit rule above.

## Test plan
- Wrap-around, ADDR_W=10, RAM preloaded mem[a]=a: `start_addr`=0x3FE, `len`=4, `m_ready`=1 → `r_addr` 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles. Beats are 0x3FE, 0x3FF, 0x000, 0x001 in cycles 3–6, and `done` is high in cycle 7 only.
- Backpressure: `len`=16, `m_ready` low for cycles 3–12, then high → at most 4 `r_en` before the first accept. All 16 words arrive in order with none duplicated, and `m_data` is stable while stalled.
- Zero length: `start` with `len`=0 → `done` high cycle 1, `r_en` never asserted, `busy` never high.
- Start while busy: a second `start` with different `start_addr` during RUN → ignored; the first transfer completes unchanged.
- Reset mid-transfer: `rst_n` low for 1 cycle after 3 of 8 beats → every output at its reset value the next cycle. No `done` pulse; a new `start` then works normally.
- With `IOB_RAM_RD_STREAM_LAST_EN`, `len`=3 → `m_last` high only on the third beat; with `len`=1 → `m_last` high on the sole beat.
